sdram_port_arbiter: RTL and testbench

Shares the single SDRAM command scheduler datapath between PORTS AHB requesters and the auto-refresh timer. Picks one requester at a time and holds a registered one-hot grant until the scheduler signals completion. Completion is routed back to the winning port as a read or write acknowledge. Priority order: refresh, starved ports, control port, round-robin.

---
 rtl/sdram_port_arbiter_if.sv | 28 ++
 rtl/sdram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Handshake bundle between the AHB requesters, refresh timer, scheduler and the
// SDRAM port arbiter. "master" is the requester/scheduler side.
interface sdram_port_arbiter_if #(
  parameter int PORTS = 2
);
  logic [PORTS-1:0] rdreq_i;
  logic [PORTS-1:0] wrreq_i;
  logic [PORTS-1:0] wbr_i;
  logic             refresh_req_i;
  logic             done_i;
  logic [PORTS-1:0] gnt_o;
  logic             gnt_wr_o;
  logic             gnt_valid_o;
  logic             refresh_gnt_o;
  logic [PORTS-1:0] rdack_o;
  logic [PORTS-1:0] wrack_o;
  logic [PORTS-1:0] starved_o;

  modport master (
    output rdreq_i, wrreq_i, wbr_i, refresh_req_i, done_i,
    input  gnt_o, gnt_wr_o, gnt_valid_o, refresh_gnt_o, rdack_o, wrack_o, starved_o
  );

  modport slave (
    input  rdreq_i, wrreq_i, wbr_i, refresh_req_i, done_i,
    output gnt_o, gnt_wr_o, gnt_valid_o, refresh_gnt_o, rdack_o, wrack_o, starved_o
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM scheduler between PORTS requesters and auto-refresh.
// Priority: refresh, starved ports, control port, round-robin.

module sdram_port_arbiter_wait_ctr #(
  parameter int MAX_WAIT = 16,
  parameter int CW       = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic gnt_i,
  output logic starved_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i)                cnt_d = '0;
    else if (cnt_q != CW'(MAX_WAIT))    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign starved_o = (cnt_q == CW'(MAX_WAIT));
endmodule

module sdram_port_arbiter #(
  parameter int PORTS     = 2,
  parameter int CTRL_PORT = 0,
  parameter int MAX_WAIT  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sdram_port_arbiter_if.slave  bus
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, PORT, REFRESH} state_e;

  state_e           state_q, state_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic             gnt_wr_q, gnt_wr_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             refresh_gnt_q, refresh_gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [PORTS-1:0] req, starved, sel_oh, load;
  logic             sel_found, sel_wr;
  logic [PW-1:0]    sel_idx;
  logic [PW:0]      idx;

  assign req = bus.rdreq_i | bus.wrreq_i;

  // Winner search; each stage only fires if nothing above it already matched.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int p = 0; p < PORTS; p++)
      if (!sel_found && req[p] && starved[p]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(p);
      end
    if (!sel_found && req[CTRL_PORT]) begin
      sel_found = 1'b1;
      sel_idx   = PW'(CTRL_PORT);
    end
    for (int k = 1; k <= PORTS; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(PORTS)) idx = idx - (PW+1)'(PORTS);
      if (!sel_found && idx[PW-1:0] != PW'(CTRL_PORT) && req[idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[PW-1:0];
      end
    end
  end

  assign sel_oh = sel_found ? (PORTS'(1) << sel_idx) : '0;
  // Write wins only when the read is blocked by write-before-read or absent.
  assign sel_wr = ~|(sel_oh & bus.rdreq_i & ~bus.wbr_i) & |(sel_oh & bus.wrreq_i);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_wr_d      = gnt_wr_q;
    gnt_valid_d   = gnt_valid_q;
    refresh_gnt_d = refresh_gnt_q;
    ptr_d         = ptr_q;
    load          = '0;
    case (state_q)
      IDLE: begin
        if (bus.refresh_req_i) begin
          state_d       = REFRESH;
          refresh_gnt_d = 1'b1;
        end else if (sel_found) begin
          state_d     = PORT;
          gnt_d       = sel_oh;
          gnt_wr_d    = sel_wr;
          gnt_valid_d = 1'b1;
          load        = sel_oh;
          if (sel_idx != PW'(CTRL_PORT)) ptr_d = sel_idx;
        end
      end
      PORT: begin
        if (bus.done_i) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_wr_d    = 1'b0;
          gnt_valid_d = 1'b0;
        end
      end
      REFRESH: begin
        if (bus.done_i) begin
          state_d       = IDLE;
          refresh_gnt_d = 1'b0;
        end
      end
      default: begin
        state_d       = IDLE;
        gnt_d         = '0;
        gnt_wr_d      = 1'b0;
        gnt_valid_d   = 1'b0;
        refresh_gnt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      gnt_wr_q      <= 1'b0;
      gnt_valid_q   <= 1'b0;
      refresh_gnt_q <= 1'b0;
      ptr_q         <= PW'(PORTS - 1);
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gnt_wr_q      <= gnt_wr_d;
      gnt_valid_q   <= gnt_valid_d;
      refresh_gnt_q <= refresh_gnt_d;
      ptr_q         <= ptr_d;
    end

  // Counter clears on the edge a port wins as well as while it holds the grant.
  sdram_port_arbiter_wait_ctr #(.MAX_WAIT(MAX_WAIT), .CW(CW)) u_wait [PORTS-1:0] (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .gnt_i    (gnt_q | load),
    .starved_o(starved)
  );

  assign bus.gnt_o         = gnt_q;
  assign bus.gnt_wr_o      = gnt_wr_q;
  assign bus.gnt_valid_o   = gnt_valid_q;
  assign bus.refresh_gnt_o = refresh_gnt_q;
  assign bus.rdack_o       = {PORTS{bus.done_i & ~gnt_wr_q}} & gnt_q;
  assign bus.wrack_o       = {PORTS{bus.done_i &  gnt_wr_q}} & gnt_q;
  assign bus.starved_o     = starved;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: dut_a (3 ports, MAX_WAIT 16) and dut_b (2 ports, MAX_WAIT 4);
// expected grants queued when requests are driven, checked when granted.
module tb_sdram_port_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  sdram_port_arbiter_if #(.PORTS(3)) ia();
  sdram_port_arbiter_if #(.PORTS(2)) ib();

  sdram_port_arbiter #(.PORTS(3), .CTRL_PORT(0), .MAX_WAIT(16)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(ia));
  sdram_port_arbiter #(.PORTS(2), .CTRL_PORT(0), .MAX_WAIT(4)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(ib));

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] q_a[$];  // {wr, gnt[2:0]}
  logic [2:0] q_b[$];  // {wr, gnt[1:0]}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_a(input string tag);
    for (int i = 0; i < 12 && !ia.gnt_valid_o; i++) tick();
    chk(tag, 32'(ia.gnt_valid_o), 1);
  endtask

  task automatic pop_a(input string tag, output logic [3:0] e);
    e = '0;
    if (q_a.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q_a.pop_front();
      chk(tag, 32'({ia.gnt_wr_o, ia.gnt_o}), 32'(e));
    end
  endtask

  task automatic pop_b(input string tag);
    logic [2:0] e;
    if (q_b.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q_b.pop_front();
      chk(tag, 32'({ib.gnt_wr_o, ib.gnt_o}), 32'(e));
    end
  endtask

  task automatic done_a(input string tag, input logic [2:0] rd, input logic [2:0] wr);
    ia.done_i = 1'b1;
    #1;
    chk({tag, "_rdack"}, 32'(ia.rdack_o), 32'(rd));
    chk({tag, "_wrack"}, 32'(ia.wrack_o), 32'(wr));
    tick();
    ia.done_i = 1'b0;
  endtask

  task automatic done_b(input string tag, input logic [1:0] rd);
    ib.done_i = 1'b1;
    #1;
    chk({tag, "_rdack"}, 32'(ib.rdack_o), 32'(rd));
    tick();
    ib.done_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;
    {ia.rdreq_i, ia.wrreq_i, ia.wbr_i, ia.refresh_req_i, ia.done_i} = '0;
    {ib.rdreq_i, ib.wrreq_i, ib.wbr_i, ib.refresh_req_i, ib.done_i} = '0;
    repeat (2) tick();
    chk("rst_gnt",       32'(ia.gnt_o), 0);
    chk("rst_valid",     32'(ia.gnt_valid_o), 0);
    chk("rst_refresh",   32'(ia.refresh_gnt_o), 0);
    chk("rst_starved_b", 32'(ib.starved_o), 0);
    rst_ni = 1'b1;
    tick();

    // Round-robin between ports 1 and 2; reset pointer makes port 1 go first.
    ia.rdreq_i = 3'b110;
    q_a.push_back(4'b0010); q_a.push_back(4'b0100);
    q_a.push_back(4'b0010); q_a.push_back(4'b0100);
    for (int r = 0; r < 4; r++) begin
      wait_a("rr_wait");
      pop_a("rr_gnt", e);
      repeat (3) tick();
      done_a("rr", e[2:0], 3'b000);
      chk("rr_idle_gap", 32'(ia.gnt_valid_o), 0);
    end
    ia.rdreq_i = 3'b000;
    tick();

    // Single read on port 1, granted the cycle after request.
    ia.rdreq_i = 3'b010;
    q_a.push_back(4'b0010);
    tick();
    chk("rd_valid", 32'(ia.gnt_valid_o), 1);
    pop_a("rd_gnt", e);
    repeat (4) tick();
    chk("rd_hold", 32'(ia.gnt_o), 32'(3'b010));
    done_a("rd", 3'b010, 3'b000);
    ia.rdreq_i = 3'b000;
    chk("rd_release", 32'(ia.gnt_o), 0);

    // Write-before-read set, then cleared.
    {ia.rdreq_i, ia.wrreq_i, ia.wbr_i} = {3'b001, 3'b001, 3'b001};
    q_a.push_back(4'b1001);
    tick();
    pop_a("wbr_gnt", e);
    tick();
    done_a("wbr", 3'b000, 3'b001);
    {ia.rdreq_i, ia.wrreq_i, ia.wbr_i} = '0;
    tick();
    {ia.rdreq_i, ia.wrreq_i} = {3'b001, 3'b001};
    q_a.push_back(4'b0001);
    tick();
    pop_a("nowbr_gnt", e);
    done_a("nowbr", 3'b001, 3'b000);
    {ia.rdreq_i, ia.wrreq_i} = '0;
    tick();

    // done_i while idle produces nothing.
    ia.done_i = 1'b1;
    #1;
    chk("idle_done_rdack", 32'(ia.rdack_o), 0);
    chk("idle_done_wrack", 32'(ia.wrack_o), 0);
    tick();
    ia.done_i = 1'b0;
    chk("idle_done_valid", 32'(ia.gnt_valid_o), 0);

    // Refresh beats a simultaneous port request.
    ia.refresh_req_i = 1'b1;
    ia.rdreq_i = 3'b001;
    q_a.push_back(4'b0001);
    tick();
    chk("ref_gnt",   32'(ia.refresh_gnt_o), 1);
    chk("ref_noport", 32'(ia.gnt_valid_o), 0);
    tick();
    done_a("ref", 3'b000, 3'b000);
    ia.refresh_req_i = 1'b0;
    chk("ref_clear", 32'(ia.refresh_gnt_o), 0);
    chk("ref_idle",  32'(ia.gnt_valid_o), 0);
    tick();
    chk("ref_after_valid", 32'(ia.gnt_valid_o), 1);
    pop_a("ref_after_gnt", e);
    done_a("ref_after", 3'b001, 3'b000);
    ia.rdreq_i = 3'b000;
    tick();

    // Starvation: port 1 waits behind control port 0 and takes the next slot.
    ib.rdreq_i = 2'b11;
    q_b.push_back(3'b001);
    tick();
    pop_b("stv_first");
    repeat (2) tick();
    chk("stv_not_yet", 32'(ib.starved_o), 0);
    tick();
    chk("stv_reached", 32'(ib.starved_o), 32'(2'b10));
    repeat (3) tick();
    done_b("stv", 2'b01);
    q_b.push_back(3'b010);
    chk("stv_hold", 32'(ib.starved_o), 32'(2'b10));
    tick();
    pop_b("stv_second");
    chk("stv_cleared", 32'(ib.starved_o), 0);
    done_b("stv2", 2'b10);
    ib.rdreq_i = 2'b00;
    tick();

    // Asynchronous reset in the middle of a grant.
    ia.rdreq_i = 3'b001;
    q_a.push_back(4'b0001);
    tick();
    pop_a("mid_gnt", e);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_gnt",     32'(ia.gnt_o), 0);
    chk("mid_rst_valid",   32'(ia.gnt_valid_o), 0);
    chk("mid_rst_wr",      32'(ia.gnt_wr_o), 0);
    chk("mid_rst_refresh", 32'(ia.refresh_gnt_o), 0);
    ia.done_i = 1'b1;
    #1;
    chk("mid_rst_rdack", 32'(ia.rdack_o), 0);
    ia.done_i = 1'b0;
    ia.rdreq_i = 3'b000;
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(ia.gnt_valid_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
